ascon_fsm: RTL and testbench
============================

# ascon_fsm

Control unit for the Ascon-128a AEAD datapath. It sequences the permutation rounds and drives the round index, the XOR-begin and XOR-end selects, the state-register enable and the ciphertext and tag capture strobes. It also runs the block-level handshake with the data source. It sits beside the permutation datapath in the top level and is the only block that writes its control inputs.

## Interface
Parameters:
- ROUNDS_A, 12, rounds of the initialisation and finalisation permutations
- ROUNDS_B, 8, rounds of each data-block permutation

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start one encryption; sampled only in IDLE
- ad_blocks_i  in  4  number of 128-bit associated-data blocks (0–15); latched at start
- pt_blocks_i  in  4  number of plaintext blocks including the padded last one; latched at start; 0 is treated as 1
- data_valid_i  in  1  data_i holds a valid block this cycle
- data_ready_o  out  1  controller accepts a block this cycle
- round_o  out  4  round-constant index, 0–11
- bypass_xor_begin_o  out  2  00 = pass, 01 = data into x0/x1, 10 = data into x0/x1 and key into x2/x3
- bypass_xor_end_o  out  2  00 = pass, 01 = key into x3/x4, 10 = x4 ^= 1 (domain separation), 11 = both
- init_state_o  out  1  state register loads IV‖K‖N instead of the permutation output
- en_state_o  out  1  state register enable
- en_cipher_o  out  1  capture x0/x1 after XOR-begin as ciphertext
- en_tag_o  out  1  capture the tag
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at the end of an encryption

## Operation
- States: IDLE, INIT_LOAD, INIT_PERM, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL_WAIT, FINAL_PERM, DONE.
- IDLE: all outputs are 0. When start_i=1, latch the block counts and go to INIT_LOAD.
- INIT_LOAD (1 cycle): init_state_o=1 and en_state_o=1. Go to INIT_PERM with the round counter at 12−ROUNDS_A.
- INIT_PERM: en_state_o=1 and round_o = the counter value.
  - On the last round (counter = 11), bypass_xor_end_o = 01.
  - If ad_blocks = 0, the last round uses 11 instead, so domain separation is still applied.
  - Exit to AD_WAIT if ad_blocks ≠ 0, otherwise to PT_WAIT if pt_blocks > 1, otherwise to FINAL_WAIT.
- The WAIT states drive data_ready_o=1. A transfer happens when data_valid_i=1 and data_ready_o=1.
  - The transfer cycle is also the first permutation round (Mealy outputs).
  - In that cycle: en_state_o=1, round_o = 12−ROUNDS_B (for AD_WAIT and PT_WAIT) or 12−ROUNDS_A (for FINAL_WAIT), and the XOR-begin select is applied.
  - AD_WAIT and PT_WAIT use XOR-begin 01. FINAL_WAIT uses 10.
  - PT_WAIT and FINAL_WAIT also assert en_cipher_o in the transfer cycle.
  - With no transfer, state and outputs hold (en_state_o=0).
- AD_PERM: runs the remaining rounds up to 11. The counter and AD block count are decremented per block.
  - After the last AD block, its round 11 uses XOR-end 10.
  - Next state is AD_WAIT if AD blocks remain, otherwise PT_WAIT if pt_blocks > 1, otherwise FINAL_WAIT.
- PT_PERM: same round sequence with XOR-end 00. Next state is PT_WAIT until pt_blocks−1 blocks have been absorbed, then FINAL_WAIT.
- FINAL_PERM: rounds up to 11. Round 11 drives XOR-end 01 and en_tag_o=1. Then go to DONE.
- DONE (1 cycle): done_o=1, then IDLE.
- Round counter is 4-bit unsigned and counts up. It never wraps past 11: reaching 11 always forces a state change.
- start_i is ignored while busy_o=1.

## Timing
- One permutation round per clock. Outputs are registered-state decoded; only the WAIT-state outputs depend combinationally on data_valid_i.
- resetb_i low, at any time and in any state: FSM goes to IDLE, counters are cleared, and every output is 0 immediately and asynchronously. There is no resumption after reset.
- Latency from the start_i sample (cycle 0) with data always valid:
  - INIT_LOAD at cycle 1, INIT_PERM over cycles 2–13.
  - Each AD and non-final PT block takes ROUNDS_B cycles.
  - The final block takes ROUNDS_A cycles; done_o follows in the next cycle.
- data_valid_i held low stalls indefinitely in a WAIT state; busy_o stays 1.

## Structure
- Package ascon_pack gains:
  - enum type_fsm_state
  - ROUNDS_A and ROUNDS_B defaults
  - named constants for the bypass_xor_begin and bypass_xor_end encodings
- Sub-module round_counter: 4-bit loadable up-counter with a load value, an enable, and an is_last (=11) flag.
- The FSM (state register, next-state logic, output decode, block counters) lives in ascon_fsm.

## Test plan
- Reset mid-INIT_PERM (cycle 7): all outputs go to 0 while resetb_i is low; after release, state is IDLE and busy_o=0.
- ad=1, pt=1, data_valid_i always 1, start at cycle 0:
  - round_o runs 0–11 over cycles 2–13, with XOR-end 01 at cycle 13.
  - AD over cycles 14–21: XOR-begin 01 at cycle 14, XOR-end 10 at cycle 21.
  - Final over cycles 22–33: XOR-begin 10 and en_cipher_o at cycle 22, en_tag_o at cycle 33.
  - done_o at cycle 34.
- ad=0, pt=2: init last round drives XOR-end 11. One PT_PERM block has en_cipher_o at its first round, then FINAL. done_o at cycle 34.
- ad=2, pt=1, with data_valid_i dropped for 5 cycles in the second AD_WAIT: en_state_o=0 and data_ready_o=1 during the stall; done_o arrives 5 cycles later (cycle 47 instead of 42).
- start_i pulsed during AD_PERM: no effect on the sequence; exactly one done_o pulse.
- pt_blocks_i=0: behaves identically to pt_blocks_i=1.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-128a control path.
package ascon_pack;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 8;

  // Round index of the last round in every permutation
  localparam logic [3:0] LAST_ROUND = 4'd11;

  // bypass_xor_begin encodings
  localparam logic [1:0] XB_PASS     = 2'b00;
  localparam logic [1:0] XB_DATA     = 2'b01;
  localparam logic [1:0] XB_DATA_KEY = 2'b10;

  // bypass_xor_end encodings
  localparam logic [1:0] XE_PASS    = 2'b00;
  localparam logic [1:0] XE_KEY     = 2'b01;
  localparam logic [1:0] XE_DOM     = 2'b10;
  localparam logic [1:0] XE_KEY_DOM = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_LOAD,
    ST_INIT_PERM,
    ST_AD_WAIT,
    ST_AD_PERM,
    ST_PT_WAIT,
    ST_PT_PERM,
    ST_FINAL_WAIT,
    ST_FINAL_PERM,
    ST_DONE
  } type_fsm_state;

  // First round-constant index of an n-round permutation (rounds end at 11)
  function automatic logic [3:0] first_round(input int rounds);
    return 4'(12 - rounds);
  endfunction

endpackage

// File: rtl/ascon_fsm_round_counter.sv
// Loadable 4-bit up-counter for the permutation round index.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] cnt_o,
  output logic       is_last_o
);

  logic [3:0] cnt_q;

  // Load has priority over increment; cleared asynchronously on reset
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)   cnt_q <= 4'd0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i)   cnt_q <= cnt_q + 4'd1;
  end

  assign cnt_o     = cnt_q;
  assign is_last_o = (cnt_q == LAST_ROUND);

endmodule

// File: rtl/ascon_fsm.sv
// Ascon-128a controller: sequences permutation rounds, XOR selects and
// the block handshake with the data source.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] ad_blocks_i,
  input  logic [3:0] pt_blocks_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic [1:0] bypass_xor_begin_o,
  output logic [1:0] bypass_xor_end_o,
  output logic       init_state_o,
  output logic       en_state_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] RA_FIRST = first_round(ROUNDS_A);
  localparam logic [3:0] RB_FIRST = first_round(ROUNDS_B);

  type_fsm_state state_q, state_d;
  logic [3:0]    ad_q, ad_d;   // AD blocks still to absorb
  logic [3:0]    pt_q, pt_d;   // PT blocks still to absorb, final one included
  logic          cnt_load, cnt_en, cnt_last;
  logic [3:0]    cnt_val, cnt;

  round_counter u_rcnt (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .is_last_o  (cnt_last)
  );

  // State and block-count registers
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      ad_q    <= 4'd0;
      pt_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
    end
  end

  // Next-state and output decode; WAIT states are Mealy on data_valid_i,
  // the transfer cycle doubling as the first round of the permutation
  always_comb begin
    state_d            = state_q;
    ad_d               = ad_q;
    pt_d               = pt_q;
    cnt_load           = 1'b0;
    cnt_val            = RA_FIRST;
    cnt_en             = 1'b0;
    data_ready_o       = 1'b0;
    round_o            = 4'd0;
    bypass_xor_begin_o = XB_PASS;
    bypass_xor_end_o   = XE_PASS;
    init_state_o       = 1'b0;
    en_state_o         = 1'b0;
    en_cipher_o        = 1'b0;
    en_tag_o           = 1'b0;
    done_o             = 1'b0;
    busy_o             = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ad_d    = ad_blocks_i;
          pt_d    = (pt_blocks_i == 4'd0) ? 4'd1 : pt_blocks_i;
          state_d = ST_INIT_LOAD;
        end
      end
      ST_INIT_LOAD: begin
        init_state_o = 1'b1;
        en_state_o   = 1'b1;
        cnt_load     = 1'b1;
        cnt_val      = RA_FIRST;
        state_d      = ST_INIT_PERM;
      end
      ST_INIT_PERM: begin
        en_state_o = 1'b1;
        round_o    = cnt;
        if (cnt_last) begin
          // Without AD the domain separation bit lands here instead
          bypass_xor_end_o = (ad_q == 4'd0) ? XE_KEY_DOM : XE_KEY;
          if (ad_q != 4'd0)     state_d = ST_AD_WAIT;
          else if (pt_q > 4'd1) state_d = ST_PT_WAIT;
          else                  state_d = ST_FINAL_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_state_o         = 1'b1;
          round_o            = RB_FIRST;
          bypass_xor_begin_o = XB_DATA;
          ad_d               = ad_q - 4'd1;
          cnt_load           = 1'b1;
          cnt_val            = RB_FIRST + 4'd1;
          state_d            = ST_AD_PERM;
        end
      end
      ST_AD_PERM: begin
        en_state_o = 1'b1;
        round_o    = cnt;
        if (cnt_last) begin
          if (ad_q == 4'd0) bypass_xor_end_o = XE_DOM;
          if (ad_q != 4'd0)     state_d = ST_AD_WAIT;
          else if (pt_q > 4'd1) state_d = ST_PT_WAIT;
          else                  state_d = ST_FINAL_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_state_o         = 1'b1;
          en_cipher_o        = 1'b1;
          round_o            = RB_FIRST;
          bypass_xor_begin_o = XB_DATA;
          pt_d               = pt_q - 4'd1;
          cnt_load           = 1'b1;
          cnt_val            = RB_FIRST + 4'd1;
          state_d            = ST_PT_PERM;
        end
      end
      ST_PT_PERM: begin
        en_state_o = 1'b1;
        round_o    = cnt;
        if (cnt_last) state_d = (pt_q > 4'd1) ? ST_PT_WAIT : ST_FINAL_WAIT;
        else          cnt_en  = 1'b1;
      end
      ST_FINAL_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_state_o         = 1'b1;
          en_cipher_o        = 1'b1;
          round_o            = RA_FIRST;
          bypass_xor_begin_o = XB_DATA_KEY;
          cnt_load           = 1'b1;
          cnt_val            = RA_FIRST + 4'd1;
          state_d            = ST_FINAL_PERM;
        end
      end
      ST_FINAL_PERM: begin
        en_state_o = 1'b1;
        round_o    = cnt;
        if (cnt_last) begin
          bypass_xor_end_o = XE_KEY;
          en_tag_o         = 1'b1;
          state_d          = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Self-checking bench for ascon_fsm: expected round indices and control
// events are queued from a timeline model and popped as the DUT emits them.
module tb_ascon_fsm;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] ad_blocks_i = 4'd0;
  logic [3:0] pt_blocks_i = 4'd0;
  logic       data_valid_i = 1'b0;
  logic       data_ready_o;
  logic [3:0] round_o;
  logic [1:0] bypass_xor_begin_o, bypass_xor_end_o;
  logic       init_state_o, en_state_o, en_cipher_o, en_tag_o, busy_o, done_o;
  logic [16:0] all_outs;

  ascon_fsm dut (
    .clock_i            (clock_i),
    .resetb_i           (resetb_i),
    .start_i            (start_i),
    .ad_blocks_i        (ad_blocks_i),
    .pt_blocks_i        (pt_blocks_i),
    .data_valid_i       (data_valid_i),
    .data_ready_o       (data_ready_o),
    .round_o            (round_o),
    .bypass_xor_begin_o (bypass_xor_begin_o),
    .bypass_xor_end_o   (bypass_xor_end_o),
    .init_state_o       (init_state_o),
    .en_state_o         (en_state_o),
    .en_cipher_o        (en_cipher_o),
    .en_tag_o           (en_tag_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  assign all_outs = {data_ready_o, round_o, bypass_xor_begin_o, bypass_xor_end_o,
                     init_state_o, en_state_o, en_cipher_o, en_tag_o, busy_o, done_o};

  always #5 clock_i = ~clock_i;

  typedef struct {
    int         cyc;
    logic [1:0] xb;
    logic [1:0] xe;
    logic       cip;
    logic       tag;
    logic       done;
  } ev_t;

  ev_t ev_q[$];
  int  rnd_q[$];
  int  n_checks = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  stall_lo = -1;
  int  stall_hi = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare whatever the DUT emits this cycle against the scoreboards
  task automatic monitor();
    ev_t e;
    int  r;
    if (init_state_o) chk("init_load_cycle", cyc, 1);
    if (en_state_o && !init_state_o) begin
      chk("round_expected", int'(rnd_q.size() > 0), 1);
      if (rnd_q.size() > 0) begin
        r = rnd_q.pop_front();
        chk("round_o", round_o, r);
      end
    end
    if (bypass_xor_begin_o != 2'd0 || bypass_xor_end_o != 2'd0 ||
        en_cipher_o || en_tag_o || done_o) begin
      chk("event_expected", int'(ev_q.size() > 0), 1);
      if (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("xor_begin", bypass_xor_begin_o, e.xb);
        chk("xor_end", bypass_xor_end_o, e.xe);
        chk("en_cipher", en_cipher_o, e.cip);
        chk("en_tag", en_tag_o, e.tag);
        chk("done", done_o, e.done);
      end
    end
  endtask

  // Sample 3 time units after the input drive point, then advance one cycle
  task automatic tick();
    #2;
    monitor();
    @(posedge clock_i);
    cyc++;
    #1;
  endtask

  task automatic push_rounds(input int first);
    for (int r = first; r <= 11; r++) rnd_q.push_back(r);
  endtask

  // Timeline model of one encryption with data always valid except one stall
  task automatic build(input int ad, input int pt, input int stall_blk,
                       input int stall_len, output int done_cyc);
    int c;
    int ptn;
    push_rounds(0);
    ev_q.push_back('{13, 2'd0, (ad == 0) ? 2'd3 : 2'd1, 1'b0, 1'b0, 1'b0});
    c = 14;
    stall_lo = -1;
    stall_hi = -1;
    for (int i = 0; i < ad; i++) begin
      if (i == stall_blk) begin
        stall_lo = c;
        stall_hi = c + stall_len;
        c += stall_len;
      end
      ev_q.push_back('{c, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0});
      push_rounds(4);
      if (i == ad - 1) ev_q.push_back('{c + 7, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0});
      c += 8;
    end
    ptn = (pt == 0) ? 1 : pt;
    for (int i = 0; i < ptn - 1; i++) begin
      ev_q.push_back('{c, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0});
      push_rounds(4);
      c += 8;
    end
    ev_q.push_back('{c, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0});
    push_rounds(0);
    ev_q.push_back('{c + 11, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0});
    c += 12;
    ev_q.push_back('{c, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1});
    done_cyc = c;
  endtask

  task automatic run_enc(input int ad, input int pt, input int stall_blk,
                         input int stall_len, input int start_again);
    int dc;
    build(ad, pt, stall_blk, stall_len, dc);
    ad_blocks_i  = 4'(ad);
    pt_blocks_i  = 4'(pt);
    data_valid_i = 1'b1;
    cyc          = 0;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc <= dc + 2) begin
      data_valid_i = !(cyc >= stall_lo && cyc < stall_hi);
      start_i      = (cyc == start_again);
      #1;
      if (cyc >= stall_lo && cyc < stall_hi) begin
        chk("stall_ready", data_ready_o, 1);
        chk("stall_en_state", en_state_o, 0);
        chk("stall_busy", busy_o, 1);
      end
      if (cyc == 5) chk("busy_running", busy_o, 1);
      if (cyc == dc + 1) chk("busy_after_done", busy_o, 0);
      tick();
    end
    start_i = 1'b0;
    chk("events_drained", ev_q.size(), 0);
    chk("rounds_drained", rnd_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #1 resetb_i = 1'b0;
    #1 chk("reset_outputs", all_outs, 0);
    @(posedge clock_i);
    #1 resetb_i = 1'b1;
    tick();
    chk("idle_outputs", all_outs, 0);

    // Reset in the middle of the initialisation permutation
    for (int r = 0; r < 5; r++) rnd_q.push_back(r);
    ad_blocks_i  = 4'd1;
    pt_blocks_i  = 4'd1;
    data_valid_i = 1'b1;
    cyc          = 0;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < 7) tick();
    resetb_i = 1'b0;
    #1 chk("midreset_outputs", all_outs, 0);
    tick();
    chk("midreset_hold", all_outs, 0);
    resetb_i = 1'b1;
    #1 chk("postreset_busy", busy_o, 0);
    tick();
    tick();
    chk("postreset_idle", all_outs, 0);
    chk("midreset_rounds", rnd_q.size(), 0);

    // Nominal: one AD block, single final block
    run_enc(1, 1, -1, 0, -1);
    tick();
    // No AD, two PT blocks
    run_enc(0, 2, -1, 0, -1);
    tick();
    // Two AD blocks, five-cycle stall in the second AD_WAIT
    run_enc(2, 1, 1, 5, -1);
    tick();
    // start_i pulsed during AD_PERM must be ignored
    run_enc(1, 1, -1, 0, 17);
    tick();
    // pt_blocks 0 behaves as 1
    run_enc(1, 0, -1, 0, -1);
    tick();
    // Longer mix: several AD and PT blocks
    run_enc(3, 3, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
